matmul_mac_engine: RTL and testbench
====================================

Name: matmul_mac_engine

Overview:
- Parametrised successor to the fixed 8x8 lab6 matrix-multiply datapath. Computes C = A x B for NxN signed matrices held in external synchronous-read RAMs, using one MAC and one pipelined read path.
- Adds an accumulate mode (C += A x B), a sticky overflow flag, a busy flag and a cycle counter.
- Sits between the A/B input RAMs and the C output RAM. The top-level controller drives it with a start/done handshake.

Parameters:
- N, 8, matrix dimension; power of two, 2..16.
- DW, 8, signed element width of A and B.
- ACCW, 2*DW+$clog2(N), signed accumulator and C element width (19 at defaults).
- AW, $clog2(N*N), RAM address width.
- CNTW, 16, width of clock_count.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- acc_mode  in  1  captured with start. 0 = overwrite C; 1 = C += A x B.
- a_addr  out  AW  A RAM read address.
- a_rdata  in  DW  A RAM data, valid 1 cycle after a_addr.
- b_addr  out  AW  B RAM read address.
- b_rdata  in  DW  B RAM data, valid 1 cycle after b_addr.
- c_addr  out  AW  C RAM address, shared by read and write.
- c_rdata  in  ACCW  C RAM read data, 1-cycle latency.
- c_we  out  1  C RAM write enable.
- c_wdata  out  ACCW  C RAM write data.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse when the matrix is complete.
- ovf  out  1  sticky overflow flag, cleared on each accepted start.
- clock_count  out  CNTW  cycles spent in ISSUE, LAST and WRITE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; all counters, acc, busy, done, ovf, c_we, clock_count and all addresses = 0.
- Storage is column-major:
  - A element (row j, col k) at j+N*k.
  - B element (row k, col i) at k+N*i.
  - C element (row j, col i) at N*i+j.
- Loop order: i outer, j middle, k inner.
- State machine:
  - IDLE: on start=1, latch acc_mode, clear ovf and clock_count, set i=j=k=0, go to ISSUE. start in any other state is ignored.
  - ISSUE (N cycles, k=0..N-1): drive a_addr=j+N*k and b_addr=k+N*i. When k=0, also drive c_addr=N*i+j as a read. After k=N-1, go to LAST.
  - LAST (1 cycle): accumulates the product for k=N-1, then go to WRITE.
  - WRITE (1 cycle): c_we=1, c_addr=N*i+j, c_wdata=acc. Advance j, then i. If i=j=N-1, go to DONE; otherwise go to ISSUE with k=0.
  - DONE (1 cycle): done=1, then go to IDLE.
- Datapath: product = a_rdata*b_rdata, full 2*DW signed, sign-extended to ACCW.
  - In the ISSUE cycle with k=1 (data for k=0 returning): acc <= base + product, where base = 0 if acc_mode=0, else c_rdata.
  - In later ISSUE cycles and in LAST: acc <= acc + product.
- Arithmetic wraps modulo 2^ACCW. ovf is set if any accumulation step overflows ACCW signed range; it is possible only in acc_mode=1.
- Timing:
  - Each element takes N+2 cycles.
  - done rises N*N*(N+2)+1 edges after the edge that sampled start: 641 at defaults.
  - clock_count = N*N*(N+2) (640 at defaults), held until the next accepted start.
- busy=1 in ISSUE, LAST and WRITE.
- Reset asserted mid-operation aborts immediately. C contents already written are left as-is; no done pulse.
- A start held high through DONE is only sampled on return to IDLE, so back-to-back runs are allowed. There is one idle cycle between runs.

Test Plan:
- Identity: A=I, B=random, acc_mode=0 -> C==B exactly; done once; clock_count=640.
- Extremes: all A=B=-128, acc_mode=0 -> every C=131072; ovf=0.
- Accumulate: run random A,B with mode 0, then again with mode 1 -> C == 2*(AxB) (mod 2^19); second clock_count=640.
- Overflow: all A=B=-128, mode 0 then mode 1 -> second run C=-262144 (wrapped); ovf=1 after the second run. A third start clears ovf.
- start pulsed during busy at cycle 100 -> ignored; done exactly once at 641; result unchanged.
- Reset pulsed at cycle 300 -> busy=0, done=0, clock_count=0 immediately. A fresh start afterwards gives the correct C and clock_count=640.

Source files
------------

// File: rtl/matmul_mac_engine.sv
// matmul_mac_engine: computes C = A x B (or C += A x B) for NxN signed matrices
// held in external synchronous-read RAMs, using one MAC and a pipelined read path.
//
// Ports:
//   clk          rising-edge clock
//   reset        asynchronous active-low reset
//   start        begin an operation (sampled in IDLE only)
//   acc_mode     captured with start: 0 = C = AxB, 1 = C += AxB
//   a_addr/a_rdata  A RAM read port (1-cycle latency), A(j,k) at j+N*k
//   b_addr/b_rdata  B RAM read port (1-cycle latency), B(k,i) at k+N*i
//   c_addr       C RAM address (read at k=0 and write in WRITE), C(j,i) at N*i+j
//   c_rdata      C RAM read data (1-cycle latency), used as base in acc_mode
//   c_we/c_wdata C RAM write strobe and data
//   busy         high in ISSUE, LAST and WRITE
//   done         one-cycle pulse after the final element is written
//   ovf          sticky signed overflow of the accumulator, cleared on start
//   clock_count  cycles spent in ISSUE, LAST and WRITE for the current run
module matmul_mac_engine #(
    parameter int unsigned N    = 8,
    parameter int unsigned DW   = 8,
    parameter int unsigned ACCW = 2*DW + $clog2(N),
    parameter int unsigned AW   = $clog2(N*N),
    parameter int unsigned CNTW = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            acc_mode,
    output logic [AW-1:0]   a_addr,
    input  logic [DW-1:0]   a_rdata,
    output logic [AW-1:0]   b_addr,
    input  logic [DW-1:0]   b_rdata,
    output logic [AW-1:0]   c_addr,
    input  logic [ACCW-1:0] c_rdata,
    output logic            c_we,
    output logic [ACCW-1:0] c_wdata,
    output logic            busy,
    output logic            done,
    output logic            ovf,
    output logic [CNTW-1:0] clock_count
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = 2*DW;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_LAST,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          i_q, i_d;
    logic [IW-1:0]          j_q, j_d;
    logic [IW-1:0]          k_q, k_d;
    logic                   mode_q, mode_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic                   ovf_q, ovf_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   c_we_q, c_we_d;
    logic [AW-1:0]          a_addr_q, a_addr_d;
    logic [AW-1:0]          b_addr_q, b_addr_d;
    logic [AW-1:0]          c_addr_q, c_addr_d;
    logic [CNTW-1:0]        cnt_q, cnt_d;

    // MAC datapath: product of the returning A/B pair added to acc or to the base
    logic signed [PW-1:0]   prod_c;
    logic signed [ACCW-1:0] prod_ext_c;
    logic signed [ACCW-1:0] base_c;
    logic signed [ACCW-1:0] lhs_c;
    logic signed [ACCW-1:0] sum_c;
    logic                   first_c;
    logic                   step_c;
    logic                   step_ovf_c;

    assign prod_c     = PW'(signed'(a_rdata)) * PW'(signed'(b_rdata));
    assign prod_ext_c = ACCW'(prod_c);
    assign base_c     = mode_q ? signed'(c_rdata) : '0;

    // Data for k=0 returns while k_q==1; that cycle seeds acc from the base.
    assign first_c    = (state_q == S_ISSUE) && (k_q == IW'(1));
    assign step_c     = ((state_q == S_ISSUE) && (k_q != '0)) || (state_q == S_LAST);
    assign lhs_c      = first_c ? base_c : acc_q;
    assign sum_c      = lhs_c + prod_ext_c;

    // Signed overflow: operands agree in sign but the wrapped sum does not.
    assign step_ovf_c = (lhs_c[ACCW-1] == prod_ext_c[ACCW-1]) &&
                        (sum_c[ACCW-1] != lhs_c[ACCW-1]);

    // Next-state, loop counters and datapath updates
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        if (step_c) begin
            acc_d = sum_c;
            ovf_d = ovf_q | step_ovf_c;
        end

        if ((state_q == S_ISSUE) || (state_q == S_LAST) || (state_q == S_WRITE)) begin
            cnt_d = cnt_q + CNTW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d  = acc_mode;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    i_d     = '0;
                    j_d     = '0;
                    k_d     = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (k_q == IW'(N-1)) begin
                    k_d     = '0;
                    state_d = S_LAST;
                end else begin
                    k_d = k_q + IW'(1);
                end
            end
            S_LAST: begin
                state_d = S_WRITE;
            end
            S_WRITE: begin
                k_d = '0;
                if (j_q == IW'(N-1)) begin
                    j_d = '0;
                    if (i_q == IW'(N-1)) begin
                        i_d     = '0;
                        state_d = S_DONE;
                    end else begin
                        i_d     = i_q + IW'(1);
                        state_d = S_ISSUE;
                    end
                end else begin
                    j_d     = j_q + IW'(1);
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Registered outputs derived from the upcoming state and counters.
    // Addresses track the next counters so they are valid throughout each cycle;
    // c_addr holds N*i+j for the whole element (read at k=0, write in WRITE).
    always_comb begin
        a_addr_d = AW'({k_d, j_d});
        b_addr_d = AW'({i_d, k_d});
        c_addr_d = AW'({i_d, j_d});
        c_we_d   = (state_d == S_WRITE);
        busy_d   = (state_d == S_ISSUE) || (state_d == S_LAST) || (state_d == S_WRITE);
        done_d   = (state_q == S_DONE);
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            ovf_q    <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            c_we_q   <= 1'b0;
            a_addr_q <= '0;
            b_addr_q <= '0;
            c_addr_q <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            k_q      <= k_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            c_we_q   <= c_we_d;
            a_addr_q <= a_addr_d;
            b_addr_q <= b_addr_d;
            c_addr_q <= c_addr_d;
        end
    end

    assign a_addr      = a_addr_q;
    assign b_addr      = b_addr_q;
    assign c_addr      = c_addr_q;
    assign c_we        = c_we_q;
    assign c_wdata     = acc_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign ovf         = ovf_q;
    assign clock_count = cnt_q;

endmodule

// File: tb/tb_matmul_mac_engine.sv
// Self-checking bench for matmul_mac_engine: RAM models around the DUT and a
// plain-arithmetic matrix product model for the expected C and overflow flag.
module tb_matmul_mac_engine;

    localparam int unsigned N    = 8;
    localparam int unsigned DW   = 8;
    localparam int unsigned ACCW = 2*DW + $clog2(N);
    localparam int unsigned AW   = $clog2(N*N);
    localparam int unsigned CNTW = 16;
    localparam int          CC_EXP    = N*N*(N+2);
    localparam int          DONE_EDGE = N*N*(N+2) + 1;
    localparam longint      MAXV = (longint'(1) <<< (ACCW-1)) - 1;
    localparam longint      MINV = -(longint'(1) <<< (ACCW-1));

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            start = 1'b0;
    logic            acc_mode = 1'b0;
    logic [AW-1:0]   a_addr, b_addr, c_addr;
    logic [DW-1:0]   a_rdata, b_rdata;
    logic [ACCW-1:0] c_rdata;
    logic            c_we;
    logic [ACCW-1:0] c_wdata;
    logic            busy, done, ovf;
    logic [CNTW-1:0] clock_count;

    logic signed [DW-1:0]   mem_a [N*N];
    logic signed [DW-1:0]   mem_b [N*N];
    logic signed [ACCW-1:0] mem_c [N*N];
    longint                 exp_c [N*N];
    bit                     exp_ovf;

    int errors = 0;
    int checks = 0;

    matmul_mac_engine #(
        .N(N), .DW(DW), .ACCW(ACCW), .AW(AW), .CNTW(CNTW)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .start(start),
        .acc_mode(acc_mode),
        .a_addr(a_addr),
        .a_rdata(a_rdata),
        .b_addr(b_addr),
        .b_rdata(b_rdata),
        .c_addr(c_addr),
        .c_rdata(c_rdata),
        .c_we(c_we),
        .c_wdata(c_wdata),
        .busy(busy),
        .done(done),
        .ovf(ovf),
        .clock_count(clock_count)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAMs with one cycle of read latency
    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr];
        b_rdata <= mem_b[b_addr];
        c_rdata <= mem_c[c_addr];
        if (c_we) mem_c[c_addr] <= c_wdata;
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic longint wrap_acc(input longint v);
        logic [ACCW-1:0] t;
        t = v[ACCW-1:0];
        return longint'(signed'(t));
    endfunction

    // Reference: C(j,i) = base + sum_k A(j,k)*B(k,i), wrapped step by step
    function automatic void model_run(input bit mode);
        exp_ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                longint acc;
                acc = mode ? longint'(mem_c[N*i+j]) : 64'sd0;
                for (int k = 0; k < N; k++) begin
                    longint t;
                    t = acc + longint'(mem_a[j+N*k]) * longint'(mem_b[k+N*i]);
                    if (t > MAXV || t < MINV) exp_ovf = 1'b1;
                    acc = wrap_acc(t);
                end
                exp_c[N*i+j] = acc;
            end
        end
    endfunction

    task automatic fill_random();
        for (int x = 0; x < N*N; x++) begin
            mem_a[x] = DW'($urandom);
            mem_b[x] = DW'($urandom);
        end
    endtask

    task automatic fill_min();
        for (int x = 0; x < N*N; x++) begin
            mem_a[x] = 8'h80;
            mem_b[x] = 8'h80;
        end
    endtask

    task automatic start_run(input string tag, input bit mode);
        @(negedge clk);
        acc_mode = mode;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, "_busy_at_start"}, longint'(busy), 1);
        check({tag, "_ovf_cleared"}, longint'(ovf), 0);
        check({tag, "_count_cleared"}, longint'(clock_count), 0);
    endtask

    task automatic wait_done(input string tag, input int pulse_at);
        int n;
        bit seen;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 4*DONE_EDGE) begin
            @(posedge clk);
            #1;
            n++;
            if (n == pulse_at) start = 1'b1;
            else if (n == pulse_at + 1) start = 1'b0;
            if (done) seen = 1'b1;
        end
        check({tag, "_done_edge"}, longint'(n), DONE_EDGE);
        check({tag, "_clock_count"}, longint'(clock_count), CC_EXP);
        check({tag, "_busy_at_done"}, longint'(busy), 0);
        check({tag, "_ovf"}, longint'(ovf), longint'(exp_ovf));
        @(posedge clk);
        #1;
        check({tag, "_done_single"}, longint'(done), 0);
    endtask

    task automatic check_c(input string tag);
        for (int x = 0; x < N*N; x++) begin
            check($sformatf("%s_c%0d", tag, x), longint'(mem_c[x]), exp_c[x]);
        end
    endtask

    task automatic full_run(input string tag, input bit mode, input int pulse_at);
        model_run(mode);
        start_run(tag, mode);
        wait_done(tag, pulse_at);
        check_c(tag);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_ovf", longint'(ovf), 0);
        check("rst_count", longint'(clock_count), 0);
        check("rst_c_we", longint'(c_we), 0);
        check("rst_a_addr", longint'(a_addr), 0);
        check("rst_c_addr", longint'(c_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Identity A with random B
        for (int x = 0; x < N*N; x++) begin
            mem_a[x] = ((x % N) == (x / N)) ? DW'(1) : DW'(0);
            mem_b[x] = DW'($urandom);
        end
        full_run("identity", 1'b0, 0);

        // Most negative operands, overwrite then accumulate (wraps)
        fill_min();
        full_run("extreme", 1'b0, 0);
        check("extreme_c0_const", longint'(mem_c[0]), 131072);
        full_run("overflow", 1'b1, 0);
        check("overflow_c_last_const", longint'(mem_c[N*N-1]), -262144);
        check("overflow_flag_const", longint'(ovf), 1);

        // Random accumulate pair; first start also clears the sticky ovf
        fill_random();
        full_run("acc_pass0", 1'b0, 0);
        full_run("acc_pass1", 1'b1, 0);

        // start pulsed while busy must be ignored
        fill_random();
        full_run("busy_start", 1'b0, 100);

        // Asynchronous reset mid-run aborts immediately
        fill_random();
        start_run("abort", 1'b0);
        for (int n = 0; n < 300; n++) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("abort_busy", longint'(busy), 0);
        check("abort_done", longint'(done), 0);
        check("abort_count", longint'(clock_count), 0);
        check("abort_c_we", longint'(c_we), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        fill_random();
        full_run("post_reset", 1'b0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
